adc_sampler: RTL

- Serial-ADC front end for the LocTag detector path: powers the LT5534 log detector, runs back-to-back conversions on the 12-bit SPI-style ADC (ADCS7476-class, 16-SCLK frame), and delivers each sample as a one-cycle valid pulse.
- Sits directly upstream of the loctag trigger/detection logic, which consumes sample/sample_valid.
- Runs on the 50 MHz PLL clock.

---
 rtl/adc_sampler_pkg.sv | 9 +
 rtl/adc_sclk_gen.sv | 28 ++
 rtl/adc_sampler.sv | 96 +++++++++
 3 files changed

// File: rtl/adc_sampler_pkg.sv
// adc_sampler_pkg: shared state encoding, frame layout defaults and warmup scaling
package adc_sampler_pkg;
  typedef enum logic [1:0] {OFF, WARMUP, QUIET, SHIFT} state_t;
  localparam int FRAME_BITS_DEF = 16;
  localparam int LEAD_BITS = 4;
  function automatic int warmup_tc(input int us, input int mhz);
    return us * mhz;
  endfunction
endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: serial clock divider (low half first) with rise/fall strobes on the last cycle of each half
module adc_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic adc_clk,
  output logic rise,
  output logic fall
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = cnt == '0;
  assign rise = tick && !adc_clk;
  assign fall = tick && adc_clk;
  always_ff @(posedge clk)
    if (!reset || !run) begin
      cnt <= '0;
      adc_clk <= 1'b1;
    end else if (tick) begin
      cnt <= CW'(CLK_DIV - 1);
      adc_clk <= ~adc_clk;
    end else begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: LT5534 power sequencing and continuous serial ADC capture; define ADC_SAMPLER_AVG4_EN for 4-frame averaged output
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int DATA_BITS    = FRAME_BITS_DEF - LEAD_BITS,
  parameter int QUIET_CYCLES = 4,
  parameter int WARMUP_US    = 10,
  parameter int CLK_MHZ      = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic                 lt5534_en,
  output logic                 adc_cs,
  output logic                 adc_clk,
  input  logic                 adc_so,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 frame_err
);
  localparam int WTC  = warmup_tc(WARMUP_US, CLK_MHZ);
  localparam int TMAX = WTC > QUIET_CYCLES ? WTC : QUIET_CYCLES;
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int BW   = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
  localparam int LEAD = FRAME_BITS - DATA_BITS;
  state_t state, nxt;
  logic [TW-1:0] tmr;
  logic [BW-1:0] bit_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic [DATA_BITS-1:0] raw, val;
  logic w_end, q_end, go, run, rise, fall, done, vok;
  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .reset(reset), .run(run), .adc_clk(adc_clk), .rise(rise), .fall(fall)
  );
  assign lt5534_en = state != OFF;
  assign adc_cs = state != SHIFT;
  assign raw = sr[DATA_BITS-1:0];
  always_comb begin
    w_end = tmr == TW'(WTC - 1);
    q_end = tmr == TW'(QUIET_CYCLES - 1);
    done = state == SHIFT && fall && bit_cnt == BW'(FRAME_BITS - 1);
    go = state == QUIET && q_end && en;
    run = go || (state == SHIFT && !done);
    nxt = state == OFF    ? (en ? WARMUP : OFF) :
          state == WARMUP ? (!en ? OFF : w_end ? QUIET : WARMUP) :
          state == QUIET  ? (q_end ? (en ? SHIFT : OFF) : QUIET) :
                            (done ? QUIET : SHIFT);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= OFF;
      tmr <= '0;
      bit_cnt <= '0;
      sr <= '0;
    end else begin
      state <= nxt;
      tmr <= (nxt != state || state == OFF || state == SHIFT) ? '0 : tmr + 1'b1;
      bit_cnt <= (state != SHIFT || done) ? '0 : fall ? bit_cnt + 1'b1 : bit_cnt;
      if (state == SHIFT && rise) sr <= {sr[FRAME_BITS-2:0], adc_so};
    end
`ifdef ADC_SAMPLER_AVG4_EN
  localparam int AW = DATA_BITS + 2;
  logic [DATA_BITS-1:0] hist [4];
  logic [AW-1:0] acc, acc_nx;
  logic [2:0] n;
  assign acc_nx = acc + AW'(raw) - AW'(hist[3]);
  assign vok = n >= 3'd3;
  assign val = acc_nx[AW-1:2];
  always_ff @(posedge clk)
    if (!reset || state == OFF) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      acc <= '0;
      n <= '0;
    end else if (done) begin
      hist[0] <= raw;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      acc <= acc_nx;
      n <= n + 3'(n != 3'd4);
    end
`else
  assign vok = 1'b1;
  assign val = raw;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      sample <= '0;
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sample_valid <= done && vok;
      frame_err <= done && |sr[FRAME_BITS-1 -: LEAD];
      if (done && vok) sample <= val;
    end
endmodule
